// File: rtl/fml_burst_reader_pkg.sv
// Shared constants and state encoding for the FML burst reader.
package fml_burst_reader_pkg;

    localparam int unsigned FML_BURST_BEATS  = 4;
    localparam int unsigned FML_BURST_STRIDE = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fml_burst_reader_fifo.sv
// Synchronous show-ahead FIFO; head word is visible whenever valid is high.
module fml_burst_reader_fifo #(
    parameter int unsigned width      = 32,
    parameter int unsigned depth_log2 = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  push,
    input  logic [width-1:0]      din,
    input  logic                  pop,
    output logic [width-1:0]      dout,
    output logic                  valid,
    output logic [depth_log2:0]   count
);

    localparam int unsigned DEPTH = 1 << depth_log2;
    localparam logic [depth_log2:0] FULL = {1'b1, {depth_log2{1'b0}}};

    logic [width-1:0]      mem [DEPTH];
    logic [depth_log2-1:0] wr_ptr;
    logic [depth_log2-1:0] rd_ptr;
    logic [depth_log2:0]   level;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop & (level != '0);
    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign do_push = push & ((level != FULL) | do_pop);

    assign dout  = mem[rd_ptr];
    assign valid = (level != '0);
    assign count = level;

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (!do_push && do_pop) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fml_burst_reader.sv
// FML read initiator: issues 4-beat bursts over a contiguous region and
// streams returned words through a credit-protected FIFO.
module fml_burst_reader
    import fml_burst_reader_pkg::*;
#(
    parameter int unsigned sdram_depth     = 25,
    parameter int unsigned fifo_depth_log2 = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   start,
    input  logic [sdram_depth-1:0] base,
    input  logic [15:0]            count,
    output logic                   busy,
    output logic                   done,
    output logic [sdram_depth-1:0] fml_adr,
    output logic                   fml_stb,
    output logic                   fml_we,
    output logic [3:0]             fml_sel,
    output logic [31:0]            fml_do,
    input  logic                   fml_eack,
    input  logic                   fml_ack,
    input  logic [31:0]            fml_di,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned CW = fifo_depth_log2 + 2;
    localparam logic [CW-1:0] DEPTH_W    = CW'(1 << fifo_depth_log2);
    localparam logic [CW-1:0] CREDIT_MIN = CW'(FML_BURST_BEATS);

    state_t                     state;
    state_t                     state_next;
    logic [sdram_depth-1:0]     adr_q;
    logic [15:0]                remaining;
    logic [fifo_depth_log2-1:0] outstanding;
    logic [1:0]                 beat_cnt;
    logic                       in_burst;
    logic [fifo_depth_log2:0]   fifo_count;
    logic [CW-1:0]              reserved;
    logic [CW-1:0]              credit;
    logic                       has_credit;
    logic                       eack_acc;
    logic                       ack_first;
    logic                       beat_write;
    logic                       burst_end;
    logic                       last_out;
    logic                       base_unused;

    assign base_unused = ^base[3:0];

    assign fml_we  = 1'b0;
    assign fml_sel = '1;
    assign fml_do  = '0;
    assign fml_adr = adr_q;
    assign busy    = (state != ST_IDLE);

    // Beats already written for the burst in progress sit in fifo_count, so
    // they are taken back out of the reservation held for outstanding bursts.
    assign reserved   = {outstanding, 2'b00} - {{fifo_depth_log2{1'b0}}, beat_cnt};
    assign credit     = DEPTH_W - {1'b0, fifo_count} - reserved;
    assign has_credit = (credit >= CREDIT_MIN);

    assign eack_acc   = fml_stb & fml_eack;
    assign ack_first  = fml_ack & ~in_burst & (outstanding != '0);
    assign beat_write = ack_first | in_burst;
    assign burst_end  = in_burst & (beat_cnt == 2'd3);
    assign last_out   = (outstanding == fifo_depth_log2'(1));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fml_stb    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && count != 16'd0) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fml_stb = (remaining != 16'd0) && has_credit;
                if (eack_acc && remaining == 16'd1) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (burst_end && last_out) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            adr_q       <= '0;
            remaining   <= '0;
            outstanding <= '0;
            beat_cnt    <= '0;
            in_burst    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;

            if (state == ST_IDLE && start) begin
                adr_q     <= {base[sdram_depth-1:4], 4'b0000};
                remaining <= count;
                done      <= (count == 16'd0);
            end

            if (eack_acc) begin
                adr_q     <= adr_q + sdram_depth'(FML_BURST_STRIDE);
                remaining <= remaining - 16'd1;
            end

            case ({eack_acc, burst_end})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            // fml_ack marks only the first beat; the other three follow back to back.
            if (ack_first) begin
                in_burst <= 1'b1;
                beat_cnt <= 2'd1;
            end else if (in_burst) begin
                beat_cnt <= beat_cnt + 2'd1;
                if (beat_cnt == 2'd3) begin
                    in_burst <= 1'b0;
                end
            end

            if (state == ST_DRAIN && burst_end && last_out) begin
                done <= 1'b1;
            end
        end
    end

    fml_burst_reader_fifo #(
        .width      (32),
        .depth_log2 (fifo_depth_log2)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push      (beat_write),
        .din       (fml_di),
        .pop       (out_valid & out_ready),
        .dout      (out_data),
        .valid     (out_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fml_burst_reader.sv
// Directed and randomized bench for fml_burst_reader with an FML controller model.
module tb_fml_burst_reader;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [24:0] base;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [24:0] fml_adr;
    logic        fml_stb;
    logic        fml_we;
    logic [3:0]  fml_sel;
    logic [31:0] fml_do;
    logic        fml_eack;
    logic        fml_ack;
    logic [31:0] fml_di;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    fml_burst_reader #(
        .sdram_depth     (25),
        .fifo_depth_log2 (4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .base      (base),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .fml_adr   (fml_adr),
        .fml_stb   (fml_stb),
        .fml_we    (fml_we),
        .fml_sel   (fml_sel),
        .fml_do    (fml_do),
        .fml_eack  (fml_eack),
        .fml_ack   (fml_ack),
        .fml_di    (fml_di),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int stb_cnt = 0;
    int issued_cnt = 0;
    int words_out = 0;
    int valid_cnt = 0;

    logic [31:0] exp_q[$];
    logic [24:0] exp_adr[$];

    logic [24:0] pend_adr[$];
    int          pend_t[$];
    logic [24:0] cur_adr;
    int          beat = 0;
    int          stb_wait = 0;
    int          eack_delay = 1;
    int          ack_lat = 5;
    int          ready_mode = 1;

    function automatic logic [31:0] mem_word(input logic [24:0] a);
        return {a, 7'h5a} ^ 32'h3c96_1e0f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: observe settled outputs at negedge, then drive the next edge's inputs.
    task automatic step();
        @(negedge sys_clk);
        cyc++;
        if (done) done_cnt++;
        if (out_valid) valid_cnt++;
        if (fml_stb) stb_cnt++;

        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom % 2);
        endcase
        if (out_valid && out_ready) begin
            chk("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
            words_out++;
        end

        if (fml_stb) begin
            if (stb_wait >= eack_delay) begin
                fml_eack = 1'b1;
                chk("adr_expected", exp_adr.size() != 0, 1);
                if (exp_adr.size() != 0) chk("fml_adr", fml_adr, exp_adr.pop_front());
                pend_adr.push_back(fml_adr);
                pend_t.push_back(cyc + ack_lat);
                issued_cnt++;
                stb_wait = 0;
            end else begin
                fml_eack = 1'b0;
                stb_wait++;
            end
        end else begin
            fml_eack = 1'b0;
            stb_wait = 0;
        end

        if (beat != 0) begin
            fml_ack = 1'b0;
            fml_di  = mem_word(cur_adr + 25'(4 * beat));
            beat    = (beat + 1) % 4;
        end else if (pend_adr.size() != 0 && pend_t[0] <= cyc) begin
            fml_ack = 1'b1;
            cur_adr = pend_adr.pop_front();
            void'(pend_t.pop_front());
            fml_di  = mem_word(cur_adr);
            beat    = 1;
        end else begin
            fml_ack = 1'b0;
            fml_di  = $urandom;
        end
    endtask

    task automatic launch(input logic [24:0] b, input logic [15:0] c, input bit accepted);
        logic [24:0] a0;
        a0 = b & ~25'hf;
        if (accepted) begin
            for (int i = 0; i < int'(c); i++) begin
                exp_adr.push_back(a0 + 25'(16 * i));
                for (int k = 0; k < 4; k++) exp_q.push_back(mem_word(a0 + 25'(16 * i + 4 * k)));
            end
        end
        start = 1'b1;
        base  = b;
        count = c;
        step();
        start = 1'b0;
    endtask

    task automatic finish_xfer(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin step(); n++; end
        while (exp_q.size() != 0 && n < budget) begin step(); n++; end
        repeat (3) step();
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_leftover"}, exp_q.size(), 0);
    endtask

    initial begin
        int w0;
        int n;
        int c;
        sys_rst_n = 1'b0;
        start     = 1'b0;
        base      = '0;
        count     = '0;
        fml_eack  = 1'b0;
        fml_ack   = 1'b0;
        fml_di    = '0;
        out_ready = 1'b0;
        ready_mode = 0;

        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stb", fml_stb, 0);
        chk("rst_adr", fml_adr, 0);
        chk("rst_valid", out_valid, 0);
        chk("fml_we", fml_we, 0);
        chk("fml_sel", fml_sel, 4'hf);
        chk("fml_do", fml_do, 0);
        sys_rst_n = 1'b1;
        step();

        // Basic three-burst read
        eack_delay = 1; ack_lat = 5; ready_mode = 1;
        issued_cnt = 0; words_out = 0;
        launch(25'h100, 16'd3, 1);
        chk("t1_busy_started", busy, 1);
        finish_xfer("t1", 300);
        chk("t1_issued", issued_cnt, 3);
        chk("t1_words", words_out, 12);

        // Zero-length transfer
        stb_cnt = 0; done_cnt = 0;
        launch(25'h40, 16'd0, 1);
        chk("t2_done_next", done, 1);
        chk("t2_busy", busy, 0);
        step();
        chk("t2_done_single", done, 0);
        repeat (5) step();
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_no_stb", stb_cnt, 0);

        // Stalled consumer limits bursts in flight
        eack_delay = 0; ack_lat = 3; ready_mode = 0;
        issued_cnt = 0; words_out = 0;
        launch(25'h2000, 16'd8, 1);
        repeat (60) step();
        chk("t3_issued_stalled", issued_cnt, 4);
        chk("t3_stb_low", fml_stb, 0);
        chk("t3_valid", out_valid, 1);
        chk("t3_words_stalled", words_out, 0);
        ready_mode = 1;
        finish_xfer("t3", 600);
        chk("t3_issued", issued_cnt, 8);
        chk("t3_words", words_out, 32);

        // Address wrap at the top of the SDRAM space
        eack_delay = 1; ack_lat = 4; ready_mode = 1;
        issued_cnt = 0; words_out = 0;
        launch(25'h1FFFFE7, 16'd4, 1);
        finish_xfer("t4", 400);
        chk("t4_issued", issued_cnt, 4);
        chk("t4_words", words_out, 16);

        // start while busy is ignored
        issued_cnt = 0; words_out = 0;
        launch(25'h3000, 16'd3, 1);
        step(); step();
        launch(25'h5550, 16'd9, 0);
        finish_xfer("t5", 400);
        chk("t5_issued", issued_cnt, 3);
        chk("t5_words", words_out, 12);

        // Reset while draining with two bursts outstanding
        eack_delay = 0; ack_lat = 12; ready_mode = 1;
        issued_cnt = 0;
        launch(25'h800, 16'd2, 1);
        n = 0;
        while (issued_cnt < 2 && n < 50) begin step(); n++; end
        step();
        chk("t6_issued", issued_cnt, 2);
        chk("t6_busy_pre", busy, 1);
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        exp_q.delete();
        exp_adr.delete();
        valid_cnt = 0; done_cnt = 0; stb_cnt = 0;
        repeat (40) step();
        chk("t6_valid_after_rst", valid_cnt, 0);
        chk("t6_done_after_rst", done_cnt, 0);
        chk("t6_busy_after_rst", busy, 0);
        chk("t6_stb_after_rst", stb_cnt, 0);

        // Randomized transfers with random controller latency and consumer stalls
        for (int t = 0; t < 6; t++) begin
            eack_delay = $urandom_range(0, 3);
            ack_lat    = $urandom_range(1, 8);
            ready_mode = 2;
            c  = $urandom_range(1, 6);
            w0 = words_out;
            issued_cnt = 0;
            launch(25'($urandom), 16'(c), 1);
            finish_xfer("rnd", 2000);
            chk("rnd_words", words_out - w0, 4 * c);
            chk("rnd_issued", issued_cnt, c);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/fml_burst_reader.md
# fml_burst_reader

FML initiator that streams a contiguous SDRAM region out of the memory controller as 32-bit words. Software/sequencer gives a base address and a burst count; the block issues read bursts (4 × 32-bit beats each) on the FML port, buffers returned beats in an internal FIFO, and presents them on a valid/ready stream toward the DSI pixel path. Flow control is credit-based so the FIFO can never overflow, with multiple bursts in flight.

## Interface
- sdram_depth, 25, FML byte-address width (must match controller)
- fifo_depth_log2, 4, log2 of FIFO depth in words (≥3; depth ≥ 8)
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; launches transfer when idle
- base  in  sdram_depth  byte start address; bits [3:0] ignored (treated 0)
- count  in  16  number of bursts to read; sampled with start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when last beat of last burst is written into FIFO
- fml_adr  out  sdram_depth  burst address, bits [3:0] always 0
- fml_stb  out  1  burst request
- fml_we  out  1  constant 0
- fml_sel  out  4  constant 4'hf
- fml_do  out  32  constant 0
- fml_eack  in  1  request accepted
- fml_ack  in  1  first read beat valid this cycle
- fml_di  in  32  read data
- out_data  out  32  FIFO head word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head word

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: busy=0, stb=0. On start: latch adr=base&~15, remaining=count; if count==0 → pulse done next cycle, stay IDLE; else → ISSUE, busy=1. start while busy ignored.
- ISSUE: fml_stb=1 whenever remaining>0 and credit≥4; adr held stable while stb high and eack low. On eack: adr+=16 (wraps mod 2^sdram_depth), remaining−=1, outstanding+=1. When remaining reaches 0 → DRAIN.
- credit = 2^fifo_depth_log2 − fifo_count − 4·outstanding − (beats_pending of current burst already counted); computed from registered values; the burst accepted in an eack cycle is included before the next stb decision.
- Return path: fml_ack starts a 4-beat sequence; beat counter 0..3 writes fml_di into FIFO each beat; on beat 3, outstanding−=1. Bursts return in issue order.
- DRAIN: wait outstanding==0; on final beat write → done pulse same cycle as last FIFO write is registered (next cycle output), → IDLE.
- fml_ack while outstanding==0 and no burst in progress: ignored, no FIFO write.
- FIFO: show-ahead; out_data valid when out_valid; pop when out_valid&out_ready. Simultaneous push/pop allowed at any occupancy, including full (credit guarantees push never when full without pop).
- Consumer stall never blocks return beats; it only throttles new requests.

## Timing
- Reset values: busy=0, done=0, fml_stb=0, fml_adr=0, out_valid=0; FIFO empty, counters 0, FSM IDLE. fml_we/sel/do constant.
- Reset mid-transfer: all state cleared next edge; in-flight beats after reset dropped (outstanding==0). Controller must be reset together.
- start at cycle T → fml_stb high at T+1 earliest.
- Back-to-back: stb may stay high through an eack cycle, next address visible T+1.
- Beat written at cycle of fml_ack (k) → out_valid at k+1 if FIFO was empty.
- With fifo_depth_log2=4: at most 4 bursts in flight when consumer idle.

## Structure
- Shared package/header: FML burst length (4 beats), burst byte stride (16), FSM state encodings.
- One sub-module: fml_burst_reader_fifo (synchronous show-ahead FIFO, parameterised width/depth_log2, exposes count).
- Top holds FSM, address/remaining/outstanding counters, beat counter, credit logic.

## Test plan
- base=0x100, count=3, out_ready=1, controller model eack 1 cycle after stb, ack 5 after eack → fml_adr 0x100,0x110,0x120; 12 words out in order; single done pulse; busy drops after.
- count=0 → no fml_stb, done pulse one cycle after start, busy stays 0.
- out_ready=0, count=8, depth 16 → exactly 4 bursts issued, stb then low; release ready → remaining 4 issued; 32 words, none lost or duplicated.
- base=2^25−32, count=4 → addresses 0x1FFFFE0, 0x1FFFFF0, 0x0, 0x10 (wrap).
- start pulsed while busy → ignored, transfer completes with original count.
- sys_rst_n low during DRAIN with 2 bursts outstanding, controller continues acking → after reset no FIFO writes, out_valid=0, no done pulse.
